tcdm_rr_arbiter_remap: RTL and testbench

Parametrised N-to-1 TCDM arbiter that merges several TCDM master ports onto one TCDM slave port. It uses round-robin arbitration and in-order response routing, with up to MAX_OUTSTANDING transactions in flight. It also provides an optional per-master address-prefix remap, which generalises the fixed fc_data 0x000->0x1c0 alias. It sits in front of SoC slaves shared by multiple masters, such as a debug plus uDMA port pair feeding one interconnect master slot.

---
 rtl/tcdm_rr_arbiter_remap_if.sv | 41 ++++
 rtl/tcdm_rr_arbiter_remap.sv | 125 ++++++++++++
 tb/tb_tcdm_rr_arbiter_remap.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tcdm_rr_arbiter_remap_if.sv
// Bundle of the N master TCDM ports and the single shared slave port around the arbiter.
// The master modport is the environment side; the slave modport is the arbiter side.
interface tcdm_rr_arbiter_remap_if #(
    parameter int NR_MASTERS = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NR_MASTERS-1:0]                m_req_i;
    logic [NR_MASTERS*ADDR_WIDTH-1:0]     m_add_i;
    logic [NR_MASTERS-1:0]                m_wen_i;
    logic [NR_MASTERS*DATA_WIDTH-1:0]     m_wdata_i;
    logic [NR_MASTERS*DATA_WIDTH/8-1:0]   m_be_i;
    logic [NR_MASTERS-1:0]                m_gnt_o;
    logic [NR_MASTERS-1:0]                m_r_valid_o;
    logic [DATA_WIDTH-1:0]                m_r_rdata_o;
    logic                                 m_r_opc_o;

    logic                                 s_req_o;
    logic [ADDR_WIDTH-1:0]                s_add_o;
    logic                                 s_wen_o;
    logic [DATA_WIDTH-1:0]                s_wdata_o;
    logic [DATA_WIDTH/8-1:0]              s_be_o;
    logic                                 s_gnt_i;
    logic                                 s_r_valid_i;
    logic [DATA_WIDTH-1:0]                s_r_rdata_i;
    logic                                 s_r_opc_i;

    modport master (
        output m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i,
        input  m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
        input  s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o,
        output s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i
    );

    modport slave (
        input  m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i,
        output m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
        output s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o,
        input  s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i
    );
endinterface

// File: rtl/tcdm_rr_arbiter_remap.sv
// N-to-1 round-robin TCDM arbiter with in-order response routing through an index FIFO
// and an optional per-master address-prefix remap.
module tcdm_rr_arbiter_remap #(
    parameter int                          NR_MASTERS      = 4,
    parameter int                          ADDR_WIDTH      = 32,
    parameter int                          DATA_WIDTH      = 32,
    parameter int                          MAX_OUTSTANDING = 4,
    parameter int                          PREFIX_WIDTH    = 12,
    parameter logic [PREFIX_WIDTH-1:0]     REMAP_FROM      = 12'h000,
    parameter logic [PREFIX_WIDTH-1:0]     REMAP_TO        = 12'h1c0,
    parameter logic [NR_MASTERS-1:0]       REMAP_EN        = 4'b0001
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    tcdm_rr_arbiter_remap_if.slave                 bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_unexpected_rsp_o
);
    localparam int IDX_W = $clog2(NR_MASTERS);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int BE_W  = DATA_WIDTH / 8;

    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       winner;
    logic                   found;
    int                     cand;
    logic [ADDR_WIDTH-1:0]  win_add;
    logic                   win_wen;
    logic [DATA_WIDTH-1:0]  win_wdata;
    logic [BE_W-1:0]        win_be;
    logic                   full;
    logic                   empty;
    logic                   handshake;
    logic                   pop;

    logic [IDX_W-1:0]       fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       fill;
    logic [IDX_W-1:0]       head;

    assign full      = (fill == CNT_W'(MAX_OUTSTANDING));
    assign empty     = (fill == '0);
    assign head      = fifo_q[rd_ptr];
    assign handshake = bus.s_req_o & bus.s_gnt_i;
    assign pop       = bus.s_r_valid_i & ~empty;

    // Rotating priority search starting at rr_ptr, then a mux of the winner's payload
    // with the prefix remap applied only for masters whose enable bit is set.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        cand      = 0;
        win_add   = '0;
        win_wen   = 1'b0;
        win_wdata = '0;
        win_be    = '0;
        for (int k = 0; k < NR_MASTERS; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NR_MASTERS) cand = cand - NR_MASTERS;
            if (!found && bus.m_req_i[IDX_W'(cand)]) begin
                found  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
        for (int i = 0; i < NR_MASTERS; i++) begin
            if (winner == IDX_W'(i)) begin
                win_add   = bus.m_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wen   = bus.m_wen_i[i];
                win_wdata = bus.m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                win_be    = bus.m_be_i[i*BE_W +: BE_W];
                if (REMAP_EN[i] && (win_add[ADDR_WIDTH-1 -: PREFIX_WIDTH] == REMAP_FROM))
                    win_add[ADDR_WIDTH-1 -: PREFIX_WIDTH] = REMAP_TO;
            end
        end
    end

    always_comb begin
        bus.s_req_o   = found & ~full;
        bus.s_add_o   = bus.s_req_o ? win_add   : '0;
        bus.s_wen_o   = bus.s_req_o ? win_wen   : 1'b0;
        bus.s_wdata_o = bus.s_req_o ? win_wdata : '0;
        bus.s_be_o    = bus.s_req_o ? win_be    : '0;
        bus.m_gnt_o     = '0;
        bus.m_r_valid_o = '0;
        for (int i = 0; i < NR_MASTERS; i++) begin
            bus.m_gnt_o[i]     = handshake && (winner == IDX_W'(i));
            bus.m_r_valid_o[i] = pop && (head == IDX_W'(i));
        end
        bus.m_r_rdata_o = bus.s_r_rdata_i;
        bus.m_r_opc_o   = bus.s_r_opc_i;
    end

    // Routing state; reset drops in-flight entries so their late responses flag as unexpected.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr               <= '0;
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            fill                 <= '0;
            err_unexpected_rsp_o <= 1'b0;
        end else begin
            if (handshake) begin
                rr_ptr <= (winner == IDX_W'(NR_MASTERS - 1)) ? '0 : winner + 1'b1;
                wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            if (handshake && !pop)
                fill <= fill + 1'b1;
            else if (!handshake && pop)
                fill <= fill - 1'b1;
            if (bus.s_r_valid_i && empty)
                err_unexpected_rsp_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (handshake)
            fifo_q[wr_ptr] <= winner;
    end

    assign outstanding_o = fill;
endmodule

// File: tb/tb_tcdm_rr_arbiter_remap.sv
// Directed-vector bench for the round-robin TCDM arbiter: grant order, remap, full stall,
// grant back-pressure and reset with in-flight responses.
module tb_tcdm_rr_arbiter_remap;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] outstanding;
    logic       err_rsp;
    int         total = 0;
    int         bad   = 0;

    tcdm_rr_arbiter_remap_if #(.NR_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    tcdm_rr_arbiter_remap dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .bus                  (bus),
        .outstanding_o        (outstanding),
        .err_unexpected_rsp_o (err_rsp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic req, input logic [31:0] add,
                                 input logic wen, input logic [31:0] wdata, input logic [3:0] be);
        bus.m_req_i[idx]            = req;
        bus.m_add_i[idx*32 +: 32]   = add;
        bus.m_wen_i[idx]            = wen;
        bus.m_wdata_i[idx*32 +: 32] = wdata;
        bus.m_be_i[idx*4 +: 4]      = be;
    endtask

    task automatic clear_masters();
        bus.m_req_i   = '0;
        bus.m_add_i   = '0;
        bus.m_wen_i   = '0;
        bus.m_wdata_i = '0;
        bus.m_be_i    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_masters();
        bus.s_gnt_i     = 1'b0;
        bus.s_r_valid_i = 1'b0;
        bus.s_r_rdata_i = '0;
        bus.s_r_opc_i   = 1'b0;
        #2;
        checkOutput("rst_outstanding", 64'(outstanding), 0);
        checkOutput("rst_err", 64'(err_rsp), 0);
        checkOutput("rst_s_req", 64'(bus.s_req_o), 0);
        checkOutput("rst_gnt", 64'(bus.m_gnt_o), 0);
        checkOutput("rst_s_add", 64'(bus.s_add_o), 0);
        tick();
        rst = 1'b0;

        // single read from master 2, response one cycle later
        applyStimulus(2, 1'b1, 32'h1c008000, 1'b1, 32'h0, 4'hf);
        bus.s_gnt_i = 1'b1;
        #1;
        checkOutput("single_gnt", 64'(bus.m_gnt_o), 64'h4);
        checkOutput("single_s_req", 64'(bus.s_req_o), 1);
        checkOutput("single_s_add", 64'(bus.s_add_o), 64'h1c008000);
        checkOutput("single_s_wen", 64'(bus.s_wen_o), 1);
        tick();
        clear_masters();
        bus.s_r_valid_i = 1'b1;
        bus.s_r_rdata_i = 32'hDEADBEEF;
        bus.s_r_opc_i   = 1'b1;
        #1;
        checkOutput("single_outst1", 64'(outstanding), 1);
        checkOutput("single_rvalid", 64'(bus.m_r_valid_o), 64'h4);
        checkOutput("single_rdata", 64'(bus.m_r_rdata_o), 64'hDEADBEEF);
        checkOutput("single_opc", 64'(bus.m_r_opc_o), 1);
        checkOutput("single_gnt_idle", 64'(bus.m_gnt_o), 0);
        tick();
        bus.s_r_valid_i = 1'b0;
        bus.s_r_opc_i   = 1'b0;
        #1;
        checkOutput("single_outst0", 64'(outstanding), 0);

        // remap applies only to master 0
        bus.s_gnt_i = 1'b0;
        applyStimulus(0, 1'b1, 32'h00001234, 1'b1, 32'h0, 4'hf);
        #1;
        checkOutput("remap_m0", 64'(bus.s_add_o), 64'h1c001234);
        checkOutput("remap_m0_gnt", 64'(bus.m_gnt_o), 0);
        clear_masters();
        applyStimulus(1, 1'b1, 32'h00001234, 1'b1, 32'h0, 4'hf);
        #1;
        checkOutput("remap_m1", 64'(bus.s_add_o), 64'h00001234);
        clear_masters();
        #1;
        checkOutput("idle_s_add", 64'(bus.s_add_o), 0);
        checkOutput("idle_s_req", 64'(bus.s_req_o), 0);

        // all four masters requesting, back-to-back grants and responses
        do_reset();
        for (int i = 0; i < 4; i++)
            applyStimulus(i, 1'b1, 32'h00100000 + 32'(i), 1'b1, 32'h0, 4'hf);
        bus.s_gnt_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput("rr_gnt", 64'(bus.m_gnt_o), 64'(1 << (k % 4)));
            checkOutput("rr_rvalid", 64'(bus.m_r_valid_o), (k == 0) ? 64'h0 : 64'(1 << ((k - 1) % 4)));
            tick();
            bus.s_r_valid_i = 1'b1;
        end
        clear_masters();
        #1;
        checkOutput("rr_last_rvalid", 64'(bus.m_r_valid_o), 64'h8);
        checkOutput("rr_last_outst", 64'(outstanding), 1);
        tick();
        bus.s_r_valid_i = 1'b0;
        #1;
        checkOutput("rr_drained", 64'(outstanding), 0);

        // FIFO full stall, no same-cycle bypass on pop
        do_reset();
        applyStimulus(2, 1'b1, 32'h00000040, 1'b1, 32'h0, 4'hf);
        bus.s_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("full_fill_gnt", 64'(bus.m_gnt_o), 64'h4);
            checkOutput("full_fill_outst", 64'(outstanding), 64'(k));
            tick();
        end
        #1;
        checkOutput("full_s_req", 64'(bus.s_req_o), 0);
        checkOutput("full_gnt", 64'(bus.m_gnt_o), 0);
        checkOutput("full_outst", 64'(outstanding), 4);
        bus.s_r_valid_i = 1'b1;
        #1;
        checkOutput("full_pop_rvalid", 64'(bus.m_r_valid_o), 64'h4);
        checkOutput("full_no_bypass", 64'(bus.s_req_o), 0);
        tick();
        bus.s_r_valid_i = 1'b0;
        #1;
        checkOutput("full_resume_outst", 64'(outstanding), 3);
        checkOutput("full_resume_gnt", 64'(bus.m_gnt_o), 64'h4);
        tick();
        #1;
        checkOutput("full_again", 64'(outstanding), 4);
        clear_masters();
        bus.s_r_valid_i = 1'b1;
        repeat (4) tick();
        bus.s_r_valid_i = 1'b0;
        #1;
        checkOutput("full_drained", 64'(outstanding), 0);

        // grant back-pressure keeps master 1 selected, then pointer moves past it
        do_reset();
        bus.s_gnt_i = 1'b0;
        applyStimulus(1, 1'b1, 32'h00002000, 1'b0, 32'hCAFEF00D, 4'b0011);
        applyStimulus(3, 1'b1, 32'h00003000, 1'b1, 32'h0, 4'hf);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("stall_s_req", 64'(bus.s_req_o), 1);
            checkOutput("stall_s_add", 64'(bus.s_add_o), 64'h00002000);
            checkOutput("stall_wdata", 64'(bus.s_wdata_o), 64'hCAFEF00D);
            checkOutput("stall_gnt", 64'(bus.m_gnt_o), 0);
            tick();
        end
        bus.s_gnt_i = 1'b1;
        #1;
        checkOutput("stall_gnt_m1", 64'(bus.m_gnt_o), 64'h2);
        checkOutput("stall_wen", 64'(bus.s_wen_o), 0);
        checkOutput("stall_be", 64'(bus.s_be_o), 64'h3);
        tick();
        #1;
        checkOutput("after_gnt_m3", 64'(bus.m_gnt_o), 64'h8);
        checkOutput("after_add_m3", 64'(bus.s_add_o), 64'h00003000);
        tick();
        clear_masters();
        bus.s_gnt_i = 1'b0;
        #1;
        checkOutput("pre_rst_outst", 64'(outstanding), 2);

        // reset with two in flight, the late response is unexpected
        rst = 1'b1;
        #1;
        checkOutput("midrst_outst", 64'(outstanding), 0);
        rst = 1'b0;
        bus.s_r_valid_i = 1'b1;
        bus.s_r_rdata_i = 32'h12345678;
        #1;
        checkOutput("unexp_rvalid", 64'(bus.m_r_valid_o), 0);
        checkOutput("unexp_err_pre", 64'(err_rsp), 0);
        tick();
        bus.s_r_valid_i = 1'b0;
        #1;
        checkOutput("unexp_err_set", 64'(err_rsp), 1);
        tick();
        tick();
        checkOutput("unexp_err_sticky", 64'(err_rsp), 1);
        checkOutput("unexp_outst", 64'(outstanding), 0);
        do_reset();
        checkOutput("err_cleared", 64'(err_rsp), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
